ha_array_accumulator: RTL and testbench
=======================================

Name: ha_array_accumulator

Overview:
- Consumer end of the unsigned 8x8 half-adder-array partial-product interface.
- Accepts one beat carrying four compressed row groups (b and t vectors per group) and reduces them serially, one group per cycle, into the final product.
- Sits between the combinational HA-array compressor and downstream logic that consumes products.
- Valid/ready handshake on both sides; one product in flight at a time.

Parameters:
- NUM_GROUPS, 4, number of HA-array groups per beat; group k has weight offset 2*k.
- OUT_W, 17, product width. Sized for the worst-case sum of approximate rows (86615), so the result never overflows.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- ha_array_0_b  input  7  group 0 carry row.
- ha_array_0_t  input  9  group 0 sum row.
- ha_array_1_b  input  7  group 1 carry row.
- ha_array_1_t  input  9  group 1 sum row.
- ha_array_2_b  input  7  group 2 carry row.
- ha_array_2_t  input  9  group 2 sum row.
- ha_array_3_b  input  7  group 3 carry row.
- ha_array_3_t  input  9  group 3 sum row.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream accepts product.
- product  output  OUT_W  accumulated product.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, in_ready=1, out_valid=0, product=0, accumulator=0, group counter=0, captured rows cleared.
- Bit weights within group k:
  - t[i] has weight i + 2k.
  - b[i] has weight i + 2 + 2k.
  - Group value G_k = (t_k + (b_k << 2)) << 2k, zero-extended to OUT_W.
- Result: product = sum over k of G_k. All arithmetic is unsigned; no truncation at OUT_W = 17.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture all eight buses into registers, clear accumulator, counter=0, go to ACC.
- ACC:
  - in_ready=0.
  - Each cycle: accumulator += G_counter (uses the captured copy), then counter++.
  - After the counter reaches NUM_GROUPS-1 and that group is added, go to DONE.
  - ACC lasts exactly NUM_GROUPS cycles.
- DONE:
  - out_valid=1; product = accumulator, registered and stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid drops next cycle and the FSM returns to IDLE.
  - in_ready is 0 in DONE. No overlap of input acceptance with output hold.
- Latency: accepted beat at cycle N produces out_valid=1 at cycle N+NUM_GROUPS+1.
- Throughput: one product per NUM_GROUPS+2 cycles when out_ready is held high.
- Input buses are sampled only at the handshake cycle. Changes on the inputs during ACC or DONE have no effect.
- in_valid while in_ready=0 is ignored. The upstream holds the beat until accepted.
- out_ready while out_valid=0 is ignored.
- product keeps its last value after handoff, until the next result is written at the end of ACC.
- Reset asserted mid-ACC or in DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse is emitted.
- Counter is log2(NUM_GROUPS) bits. It never wraps inside ACC, because the exit condition is checked before increment.

Test Plan:
- Reset then all buses 0, in_valid=1 -> accepted at cycle 1; out_valid=1 at cycle 6 with product=0; in_ready=0 cycles 2-6.
- ha_array_0_t=9'h001, all else 0 -> product=1. Separately, ha_array_3_b=7'h40 only -> product=16384 (weight 6+2+6=14).
- All t=9'h1FF, all b=7'h7F -> each group value base 1019; product=1019*85=86615 (17'h15257), no overflow.
- out_ready held 0 for 5 cycles after out_valid -> product and out_valid stable. in_valid pulses are ignored with in_ready=0. Releasing out_ready gives one handshake, then IDLE with in_ready=1.
- rst_n asserted during the third ACC cycle -> out_valid stays 0, product=0, in_ready=1 immediately; the next beat (ha_array_1_t=9'h001) yields product=4.
- Back-to-back beats with out_ready=1 -> products issued every 6 cycles, matching a reference sum model for 1000 random bus values.

Source files
------------

// File: rtl/ha_array_accumulator.sv
// Serial reducer for the 8x8 half-adder-array partial products: captures one beat
// of four (b, t) row groups and adds one weighted group per cycle into the product.
module ha_array_accumulator #(
  parameter int NUM_GROUPS = 4,
  parameter int OUT_W      = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ha_array_0_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [6:0]       ha_array_1_b,
  input  logic [8:0]       ha_array_1_t,
  input  logic [6:0]       ha_array_2_b,
  input  logic [8:0]       ha_array_2_t,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] product
);

  localparam int PORT_GROUPS = 4;
  localparam int CNT_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [OUT_W-1:0] product_reg;
  logic [OUT_W-1:0] acc_reg;
  logic [OUT_W-1:0] acc_next;
  logic [OUT_W-1:0] group_sel;
  logic [CNT_W-1:0] cnt_reg;

  logic [6:0]       b_port    [PORT_GROUPS];
  logic [8:0]       t_port    [PORT_GROUPS];
  logic [6:0]       b_src     [NUM_GROUPS];
  logic [8:0]       t_src     [NUM_GROUPS];
  logic [6:0]       b_cap_reg [NUM_GROUPS];
  logic [8:0]       t_cap_reg [NUM_GROUPS];
  logic [OUT_W-1:0] group_val [NUM_GROUPS];

  assign b_port[0] = ha_array_0_b;
  assign t_port[0] = ha_array_0_t;
  assign b_port[1] = ha_array_1_b;
  assign t_port[1] = ha_array_1_t;
  assign b_port[2] = ha_array_2_b;
  assign t_port[2] = ha_array_2_t;
  assign b_port[3] = ha_array_3_b;
  assign t_port[3] = ha_array_3_t;

  // Group k: t[i] weighs i+2k, b[i] weighs i+2+2k.
  generate
    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_group
      if (gi < PORT_GROUPS) begin : g_port
        assign b_src[gi] = b_port[gi];
        assign t_src[gi] = t_port[gi];
      end else begin : g_none
        assign b_src[gi] = '0;
        assign t_src[gi] = '0;
      end
      assign group_val[gi] =
        (OUT_W'(t_cap_reg[gi]) + (OUT_W'(b_cap_reg[gi]) << 2)) << (2 * gi);
    end
  endgenerate

  assign group_sel = group_val[cnt_reg];
  assign acc_next  = acc_reg + group_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      product_reg   <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      for (int i = 0; i < NUM_GROUPS; i++) begin
        b_cap_reg[i] <= '0;
        t_cap_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_GROUPS; i++) begin
              b_cap_reg[i] <= b_src[i];
              t_cap_reg[i] <= t_src[i];
            end
            acc_reg      <= '0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= ACC;
          end
        end
        ACC: begin
          acc_reg <= acc_next;
          // Exit is decided before incrementing so the counter never wraps.
          if (cnt_reg == LAST_GROUP) begin
            product_reg   <= acc_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign product   = product_reg;

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Scoreboard bench for ha_array_accumulator: directed corner beats plus 1000
// random back-to-back beats checked against a plain-arithmetic product model.
module tb_ha_array_accumulator;

  localparam int NG = 4;
  localparam int OW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] product;
  logic [6:0]    b_drv [NG];
  logic [8:0]    t_drv [NG];

  logic [6:0]    bv [NG];
  logic [8:0]    tv [NG];

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int cyc = 0;
  int last_hs = -1;
  int txn = 0;
  bit spacing_en = 1'b0;

  ha_array_accumulator #(.NUM_GROUPS(NG), .OUT_W(OW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_b (b_drv[0]),
    .ha_array_0_t (t_drv[0]),
    .ha_array_1_b (b_drv[1]),
    .ha_array_1_t (t_drv[1]),
    .ha_array_2_b (b_drv[2]),
    .ha_array_2_t (t_drv[2]),
    .ha_array_3_b (b_drv[3]),
    .ha_array_3_t (t_drv[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Product = sum over groups of (t + 4*b) * 4^k.
  function automatic int ref_product(input logic [6:0] b [NG], input logic [8:0] t [NG]);
    int sum = 0;
    for (int k = 0; k < NG; k++)
      sum += (int'(t[k]) + 4 * int'(b[k])) * (4 ** k);
    return sum;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_vecs();
    for (int k = 0; k < NG; k++) begin
      bv[k] = '0;
      tv[k] = '0;
    end
  endtask

  task automatic random_vecs();
    for (int k = 0; k < NG; k++) begin
      bv[k] = 7'($urandom);
      tv[k] = 9'($urandom);
    end
  endtask

  // Drive bv/tv and hold until accepted; exp < 0 means use the model.
  task automatic send_beat(input int exp);
    int budget = 0;
    for (int k = 0; k < NG; k++) begin
      b_drv[k] = bv[k];
      t_drv[k] = tv[k];
    end
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && budget < 100) begin
      tick();
      budget++;
    end
    if (budget >= 100) begin
      check("accept_timeout", in_ready, 1);
    end else begin
      exp_q.push_back(exp < 0 ? ref_product(bv, tv) : exp);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < NG; k++) begin
      b_drv[k] = 7'($urandom);
      t_drv[k] = 9'($urandom);
    end
  endtask

  task automatic wait_out(output int lat, output bit ready_low);
    lat = 0;
    ready_low = 1'b1;
    while (out_valid !== 1'b1 && lat < 50) begin
      if (in_ready !== 1'b0) ready_low = 1'b0;
      tick();
      lat++;
    end
    if (in_ready !== 1'b0) ready_low = 1'b0;
  endtask

  task automatic run_one(input int exp);
    int  lat;
    bit  rl;
    send_beat(exp);
    wait_out(lat, rl);
    check("out_valid_timeout", out_valid, 1);
    tick();
  endtask

  // Monitor: every output handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got product=%0d expected no output", product);
      end else begin
        int e;
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d cycle %0d product=%0d expected=%0d", txn, cyc, product, e);
        check("product", product, e);
        if (spacing_en && last_hs >= 0) check("spacing", cyc - last_hs, NG + 2);
        last_hs = cyc;
      end
    end
  end

  initial begin
    int  lat;
    int  e;
    int  budget;
    bit  rl;

    for (int k = 0; k < NG; k++) begin
      b_drv[k] = '0;
      t_drv[k] = '0;
    end
    repeat (3) tick();
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_product", product, 0);
    rst_n = 1'b1;

    // All-zero beat: latency and in_ready low through ACC and DONE.
    out_ready = 1'b1;
    clear_vecs();
    send_beat(0);
    wait_out(lat, rl);
    check("latency", lat, NG);
    check("in_ready_low_acc_done", rl, 1);
    tick();
    check("in_ready_after_handoff", in_ready, 1);
    check("out_valid_after_handoff", out_valid, 0);

    clear_vecs();
    tv[0] = 9'h001;
    run_one(1);
    clear_vecs();
    bv[3] = 7'h40;
    run_one(16384);
    for (int k = 0; k < NG; k++) begin
      bv[k] = 7'h7F;
      tv[k] = 9'h1FF;
    end
    run_one(86615);

    // Backpressure: output must hold while in_valid pulses are ignored.
    out_ready = 1'b0;
    random_vecs();
    e = ref_product(bv, tv);
    send_beat(e);
    wait_out(lat, rl);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      for (int k = 0; k < NG; k++) begin
        b_drv[k] = 7'($urandom);
        t_drv[k] = 9'($urandom);
      end
      check("hold_out_valid", out_valid, 1);
      check("hold_product", product, e);
      check("hold_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("product_kept", product, e);
    tick();
    check("no_second_output", out_valid, 0);

    // Reset during the third ACC cycle discards the beat.
    random_vecs();
    send_beat(-1);
    void'(exp_q.pop_back());
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midacc_rst_out_valid", out_valid, 0);
    check("midacc_rst_product", product, 0);
    check("midacc_rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("post_rst_out_valid", out_valid, 0);
    clear_vecs();
    tv[1] = 9'h001;
    run_one(4);

    // Random back-to-back beats.
    last_hs = -1;
    spacing_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      random_vecs();
      send_beat(-1);
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      tick();
      budget++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    spacing_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
